// File: rtl/frame_plotter.sv
// Pixel sink: FIFO-queued plot requests drain to the VGA write port; owns the per-frame clear sweep.
// Optional input clipping is enabled by defining FRAME_PLOTTER_CLIP_EN.
module frame_plotter #(
    parameter int          SCREEN_W   = 160,
    parameter int          SCREEN_H   = 120,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [2:0]  BG_COLOR   = 3'b000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [2:0]  color,
    input  logic        plot,
    input  logic        clear_req,
    output logic        in_ready,
    output logic [9:0]  vga_x,
    output logic [9:0]  vga_y,
    output logic [2:0]  vga_color,
    output logic        vga_plot,
    output logic        clear_busy,
    output logic        frame_done,
    output logic        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] color;
    } pix_t;

    typedef enum logic [1:0] {IDLE, CLEAR, DRAIN} state_t;

    state_t         state, state_nx;
    pix_t           mem [FIFO_DEPTH];
    pix_t           head;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count, count_nx;
    logic [9:0]     cx, cy;
    logic           clear_pend;
    logic           clip_pass, push, drop, pop;
    logic           start_clear, sweep_last;

`ifdef FRAME_PLOTTER_CLIP_EN
    assign clip_pass = (x < 10'(SCREEN_W)) && (y < 10'(SCREEN_H));
`else
    assign clip_pass = 1'b1;
`endif

    assign in_ready    = (count != (AW+1)'(FIFO_DEPTH));
    assign push        = plot & in_ready & clip_pass;
    assign drop        = plot & ~in_ready & clip_pass;
    assign start_clear = (state == IDLE) && (clear_req || clear_pend);
    assign sweep_last  = (state == CLEAR) && (cx == 10'(SCREEN_W-1)) && (cy == 10'(SCREEN_H-1));
    assign clear_busy  = (state == CLEAR);
    assign head        = mem[rd_ptr];

    // IDLE pops directly so a lone pixel reaches the adapter one edge after it is queued.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        count_nx = count;
        case (state)
            IDLE: begin
                if (start_clear) begin
                    state_nx = CLEAR;
                end else if (count != '0) begin
                    pop = 1'b1;
                end
            end
            DRAIN:   pop = (count != '0);
            default: ;
        endcase
        count_nx = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        if (pop || sweep_last)
            state_nx = (count_nx != '0) ? DRAIN : IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            cx         <= '0;
            cy         <= '0;
            clear_pend <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            frame_done <= sweep_last;
            overflow   <= drop | (overflow & ~sweep_last);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            // A clear requested mid-drain waits until the queue empties.
            if (start_clear)
                clear_pend <= 1'b0;
            else if (clear_req && state == DRAIN)
                clear_pend <= 1'b1;
            if (start_clear) begin
                cx <= '0;
                cy <= '0;
            end else if (state == CLEAR) begin
                if (cx == 10'(SCREEN_W-1)) begin
                    cx <= '0;
                    cy <= cy + 1'b1;
                end else begin
                    cx <= cx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{x: x, y: y, color: color};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga_x     <= '0;
            vga_y     <= '0;
            vga_color <= '0;
            vga_plot  <= 1'b0;
        end else if (state == CLEAR) begin
            vga_x     <= cx;
            vga_y     <= cy;
            vga_color <= BG_COLOR;
            vga_plot  <= 1'b1;
        end else if (pop) begin
            vga_x     <= head.x;
            vga_y     <= head.y;
            vga_color <= head.color;
            vga_plot  <= 1'b1;
        end else begin
            vga_plot  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_frame_plotter.sv
// Bench for frame_plotter: vector table for single pixels, scoreboard for queued pixels,
// hand sequences for sweep, overflow, clear/plot collision and mid-sweep reset.
module tb_frame_plotter;
    localparam int         W  = 160;
    localparam int         H  = 120;
    localparam logic [2:0] BG = 3'b000;
`ifdef FRAME_PLOTTER_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] x, y;
    logic [2:0] color;
    logic       plot, clear_req;
    logic       in_ready, vga_plot, clear_busy, frame_done, overflow;
    logic [9:0] vga_x, vga_y;
    logic [2:0] vga_color;

    frame_plotter dut (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y), .color(color), .plot(plot),
        .clear_req(clear_req), .in_ready(in_ready), .vga_x(vga_x), .vga_y(vga_y),
        .vga_color(vga_color), .vga_plot(vga_plot), .clear_busy(clear_busy),
        .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [22:0] sb [$];
    logic [22:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Queued-pixel monitor; sweep writes are handled by the sequences.
    always @(negedge clk) begin
        if (reset_n && vga_plot && !clear_busy && !frame_done) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                mon_exp = sb.pop_front();
                check("sb_pixel", {9'd0, vga_x, vga_y, vga_color}, {9'd0, mon_exp});
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic wait_frame_done(output int bad);
        bit seen = 1'b0;
        bad = 0;
        for (int i = 0; i < 19400 && !seen; i++) begin
            @(negedge clk);
            if (vga_plot && clear_busy && vga_color !== BG) bad++;
            if (frame_done) seen = 1'b1;
        end
        check("frame_done_seen", {31'd0, seen}, 1);
    endtask

    task automatic wait_sb_empty(input string name);
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        check(name, sb.size(), 0);
    endtask

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] c;
        logic       exp;
    } vec_t;
    vec_t vt [5];

    initial begin
        int busy, wr, fd, bad, mc;
        logic [19:0] first_xy, last_xy;
        logic [9:0]  last_x;

        vt[0] = '{x: 10'd5,   y: 10'd7,   c: 3'b101, exp: 1'b1};
        vt[1] = '{x: 10'd0,   y: 10'd0,   c: 3'b111, exp: 1'b1};
        vt[2] = '{x: 10'd159, y: 10'd119, c: 3'b010, exp: 1'b1};
        vt[3] = '{x: 10'd200, y: 10'd5,   c: 3'b001, exp: !CLIP};
        vt[4] = '{x: 10'd3,   y: 10'd300, c: 3'b100, exp: !CLIP};

        reset_n = 1'b0; x = '0; y = '0; color = '0; plot = 1'b0; clear_req = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_vga_plot", vga_plot, 0);
        check("rst_vga_xyc", {vga_x, vga_y, vga_color}, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy_done_ovf", {clear_busy, frame_done, overflow}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single pixels from the table: one-cycle latency, one-cycle write, values held after.
        last_x = '0;
        for (int i = 0; i < 5; i++) begin
            plot = 1'b1; x = vt[i].x; y = vt[i].y; color = vt[i].c;
            if (vt[i].exp) begin
                sb.push_back({vt[i].x, vt[i].y, vt[i].c});
                last_x = vt[i].x;
            end
            @(negedge clk);
            plot = 1'b0;
            @(negedge clk);
            check("vec_plot", vga_plot, vt[i].exp);
            @(negedge clk);
            check("vec_plot_off", vga_plot, 0);
            check("vec_hold_x", vga_x, last_x);
        end
        check("vec_overflow", overflow, 0);

        // Back-to-back burst while idle drains in order.
        for (int i = 0; i < 4; i++) begin
            plot = 1'b1; x = 10'(40 + i); y = 10'(50 + i); color = 3'(i + 1);
            sb.push_back({10'(40 + i), 10'(50 + i), 3'(i + 1)});
            @(negedge clk);
        end
        plot = 1'b0;
        wait_sb_empty("burst_drained");

        // Full sweep.
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        busy = 0; wr = 0; fd = 0; bad = 0; first_xy = '1; last_xy = '0;
        for (int i = 0; i < 19400; i++) begin
            if (clear_busy) busy++;
            if (vga_plot) begin
                wr++;
                if (vga_color !== BG) bad++;
                if (wr == 1) first_xy = {vga_x, vga_y};
                last_xy = {vga_x, vga_y};
            end
            if (frame_done) begin
                fd++;
                break;
            end
            @(negedge clk);
        end
        check("sweep_busy_cycles", busy, W * H);
        check("sweep_writes", wr, W * H);
        check("sweep_bg_color", bad, 0);
        check("sweep_first_xy", {12'd0, first_xy}, {12'd0, 10'd0, 10'd0});
        check("sweep_last_xy", {12'd0, last_xy}, {12'd0, 10'(W - 1), 10'(H - 1)});
        check("sweep_frame_done", fd, 1);
        @(negedge clk);
        check("sweep_done_pulse", frame_done, 0);
        check("sweep_idle_plot", vga_plot, 0);

        // Overflow during a sweep.
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        mc = 0;
        for (int i = 0; i < 20; i++) begin
            plot = 1'b1; x = 10'(i); y = 10'(i + 1); color = 3'(i);
            check("ovf_in_ready", in_ready, mc < 16);
            if (mc < 16) begin
                sb.push_back({10'(i), 10'(i + 1), 3'(i)});
                mc++;
            end
            @(negedge clk);
        end
        plot = 1'b0;
        check("ovf_set", overflow, 1);
        check("ovf_full", in_ready, 0);
        wait_frame_done(bad);
        check("ovf_sweep_bg", bad, 0);
        check("ovf_cleared", overflow, 0);
        wait_sb_empty("ovf_drained");
        check("ovf_ready_again", in_ready, 1);

        // clear_req with plot in the same cycle: sweep first, pixel right after frame_done.
        clear_req = 1'b1; plot = 1'b1; x = 10'd10; y = 10'd10; color = 3'b110;
        sb.push_back({10'd10, 10'd10, 3'b110});
        @(negedge clk);
        clear_req = 1'b0; plot = 1'b0;
        wait_frame_done(bad);
        check("coll_sweep_bg", bad, 0);
        check("coll_deferred", sb.size(), 1);
        @(negedge clk);
        check("coll_plot", vga_plot, 1);
        check("coll_xy", {vga_x, vga_y}, {10'd10, 10'd10});

        // Reset mid-sweep with a pixel queued.
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0; plot = 1'b1; x = 10'd20; y = 10'd20; color = 3'b011;
        @(negedge clk);
        plot = 1'b0;
        repeat (5000) @(negedge clk);
        check("mid_sweep_busy", clear_busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_vga", {vga_plot, vga_x, vga_y, vga_color}, 0);
        check("arst_flags", {clear_busy, frame_done, overflow}, 0);
        check("arst_in_ready", in_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        sb.delete();
        wr = 0;
        repeat (30) begin
            @(negedge clk);
            if (vga_plot) wr++;
        end
        check("post_rst_no_writes", wr, 0);
        check("post_rst_idle", clear_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
